// File: rtl/sample_frame_packer_pkg.sv
// Shared types and constants for the sample frame packer: FSM states,
// frame geometry and the bit layout of the downstream control word.
package sample_frame_packer_pkg;

  localparam int DATA_W       = 16;
  localparam int FRAME_LEN    = 10;
  localparam int IDX_W        = 4;
  localparam int SLOT_W       = DATA_W + 1;
  localparam int WORD_W       = 32;

  localparam int AP_START_BIT = 16;
  localparam int EMPTY_N_BIT  = 17;
  localparam int FULL_N_BIT   = 18;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FILL       = 3'd1,
    WAIT_SPACE = 3'd2,
    EMIT       = 3'd3,
    DONE       = 3'd4
  } state_e;

  // Slot layout is {valid, sample}; an invalid (padding) slot carries empty_n = 0.
  function automatic logic [WORD_W-1:0] pack_word(input logic [SLOT_W-1:0] slot);
    logic [WORD_W-1:0] w;
    w               = '0;
    w[DATA_W-1:0]   = slot[DATA_W-1:0];
    w[AP_START_BIT] = 1'b1;
    w[EMPTY_N_BIT]  = slot[DATA_W];
    w[FULL_N_BIT]   = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/sample_frame_packer_frame_buf.sv
// Frame buffer: DEPTH x W register file, one write port, one async read port,
// and a single-cycle clear of every slot.
module frame_buf #(
  parameter int DEPTH = sample_frame_packer_pkg::FRAME_LEN,
  parameter int W     = sample_frame_packer_pkg::SLOT_W,
  parameter int IW    = sample_frame_packer_pkg::IDX_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic [IW-1:0] rd_idx_i,
  input  logic          clr_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Clear has priority so a frame boundary never leaks a stale valid flag.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_i && (wr_idx_i < IW'(DEPTH))) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = (rd_idx_i < IW'(DEPTH)) ? mem_q[rd_idx_i] : '0;

endmodule

// File: rtl/sample_frame_packer.sv
// Collects up to FRAME_LEN samples into a frame, waits for downstream room,
// then bursts the frame as FRAME_LEN gap-free control words.
module sample_frame_packer #(
  parameter int FRAME_LEN = sample_frame_packer_pkg::FRAME_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] smp_data,
  input  logic        smp_valid,
  input  logic        smp_last,
  output logic        smp_ready,
  output logic [31:0] pkt_dout,
  output logic        pkt_wr_en,
  input  logic        pkt_full,
  input  logic        pkt_prog_full,
  output logic        busy,
  output logic [15:0] frame_cnt
);
  import sample_frame_packer_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e              state_q;
  logic [IDX_W-1:0]    fill_q;
  logic [IDX_W-1:0]    emit_q;
  logic                rdy_q;
  logic                wr_q;
  logic [WORD_W-1:0]   dout_q;
  logic [15:0]         frame_cnt_q;

  logic                buf_wr;
  logic                buf_clr;
  logic [SLOT_W-1:0]   buf_rd;

  assign buf_wr  = (state_q == FILL) && rdy_q && smp_valid;
  assign buf_clr = (state_q == DONE);

  frame_buf #(
    .DEPTH(FRAME_LEN),
    .W    (SLOT_W),
    .IW   (IDX_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (buf_wr),
    .wr_idx_i (fill_q),
    .wr_data_i({1'b1, smp_data}),
    .rd_idx_i (emit_q),
    .clr_i    (buf_clr),
    .rd_data_o(buf_rd)
  );

  // Word output and write strobe are registered, so the first word appears
  // one cycle after EMIT is entered and the strobe drops cleanly in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fill_q      <= '0;
      emit_q      <= '0;
      rdy_q       <= 1'b0;
      wr_q        <= 1'b0;
      dout_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      wr_q   <= 1'b0;
      dout_q <= '0;
      case (state_q)
        IDLE: begin
          state_q <= FILL;
          rdy_q   <= 1'b1;
        end
        FILL: begin
          if (rdy_q && smp_valid) begin
            fill_q <= fill_q + 1'b1;
            if (smp_last || (fill_q == LAST_IDX)) begin
              state_q <= WAIT_SPACE;
              rdy_q   <= 1'b0;
            end
          end
        end
        WAIT_SPACE: begin
          if (!pkt_prog_full && !pkt_full) begin
            state_q <= EMIT;
            emit_q  <= '0;
          end
        end
        // Overflow during the burst is the producer's contract; never stall here.
        EMIT: begin
          wr_q   <= 1'b1;
          dout_q <= pack_word(buf_rd);
          emit_q <= emit_q + 1'b1;
          if (emit_q == LAST_IDX) state_q <= DONE;
        end
        DONE: begin
          frame_cnt_q <= frame_cnt_q + 16'd1;
          fill_q      <= '0;
          emit_q      <= '0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign smp_ready = rdy_q;
  assign pkt_wr_en = wr_q;
  assign pkt_dout  = dout_q;
  assign busy      = (state_q != IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sample_frame_packer.sv
// Directed bench for sample_frame_packer: hand-computed words, burst timing,
// backpressure, mid-burst reset and frame counter wrap.
module tb_sample_frame_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] smp_data;
  logic        smp_valid;
  logic        smp_last;
  logic        smp_ready;
  logic [31:0] pkt_dout;
  logic        pkt_wr_en;
  logic        pkt_full;
  logic        pkt_prog_full;
  logic        busy;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] words[$];
  int          wcyc[$];
  int          cyc      = 0;
  int          rdy_viol = 0;
  int          dout_viol = 0;

  sample_frame_packer #(.FRAME_LEN(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .smp_data     (smp_data),
    .smp_valid    (smp_valid),
    .smp_last     (smp_last),
    .smp_ready    (smp_ready),
    .pkt_dout     (pkt_dout),
    .pkt_wr_en    (pkt_wr_en),
    .pkt_full     (pkt_full),
    .pkt_prog_full(pkt_prog_full),
    .busy         (busy),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  // Capture every written word shortly after the edge that registers it.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (pkt_wr_en) begin
      words.push_back(pkt_dout);
      wcyc.push_back(cyc);
      if (smp_ready) rdy_viol++;
    end else if (pkt_dout !== 32'h0) begin
      dout_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sample is accepted.
  task automatic send(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    smp_data  = d;
    smp_valid = 1'b1;
    smp_last  = l;
    while (!smp_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
    @(negedge clk);
    smp_valid = 1'b0;
    smp_last  = 1'b0;
  endtask

  task automatic wait_words(input int cnt, input string tag);
    int n;
    n = 0;
    while (words.size() < cnt && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(words.size()), 32'(cnt));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int hold_viol;
    rst           = 1'b1;
    smp_data      = '0;
    smp_valid     = 1'b0;
    smp_last      = 1'b0;
    pkt_full      = 1'b0;
    pkt_prog_full = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_ready", 32'(smp_ready), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_wr_en", 32'(pkt_wr_en), 32'd0);
    chk("rst_dout",  pkt_dout,       32'h0);
    chk("rst_cnt",   32'(frame_cnt), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("fill_ready", 32'(smp_ready), 32'd1);
    chk("fill_busy",  32'(busy),      32'd1);

    // Full frame of ten samples plus latency from last accept to first word.
    words.delete(); wcyc.delete();
    for (int k = 1; k <= 10; k++) send(16'(k), 1'b0);
    chk("lat_a", 32'(pkt_wr_en), 32'd0);
    @(negedge clk);
    chk("lat_b", 32'(pkt_wr_en), 32'd0);
    @(negedge clk);
    chk("lat_c", 32'(pkt_wr_en), 32'd1);
    wait_words(10, "full_cnt");
    for (int k = 0; k < 10; k++) chk("full_word", words[k], 32'h0007_0001 + 32'(k));
    chk("full_gapless", 32'(wcyc[9] - wcyc[0]), 32'd9);
    chk("full_frames",  32'(frame_cnt), 32'd1);

    // Short frame terminated by smp_last, padded with invalid slots.
    words.delete(); wcyc.delete();
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b1);
    wait_words(10, "short_cnt");
    chk("short_w0", words[0], 32'h0007_1111);
    chk("short_w1", words[1], 32'h0007_2222);
    chk("short_w2", words[2], 32'h0007_3333);
    for (int k = 3; k < 10; k++) chk("short_pad", words[k], 32'h0005_0000);
    chk("short_gapless", 32'(wcyc[9] - wcyc[0]), 32'd9);
    chk("short_frames",  32'(frame_cnt), 32'd2);

    // Backpressure: prog_full for 50 cycles, then full for 5 more.
    words.delete(); wcyc.delete();
    pkt_prog_full = 1'b1;
    for (int k = 0; k < 10; k++) send(16'h0100 + 16'(k), 1'b0);
    hold_viol = 0;
    repeat (50) begin
      if (pkt_wr_en || smp_ready) hold_viol++;
      @(negedge clk);
    end
    chk("pf_hold", 32'(hold_viol), 32'd0);
    pkt_prog_full = 1'b0;
    pkt_full      = 1'b1;
    hold_viol = 0;
    repeat (5) begin
      @(negedge clk);
      if (pkt_wr_en || smp_ready) hold_viol++;
    end
    chk("full_hold", 32'(hold_viol), 32'd0);
    pkt_full = 1'b0;
    @(negedge clk);
    chk("pf_emit_enter", 32'(pkt_wr_en), 32'd0);
    @(negedge clk);
    chk("pf_first_wr", 32'(pkt_wr_en), 32'd1);
    chk("pf_first_word", pkt_dout, 32'h0007_0100);
    wait_words(10, "pf_cnt");
    chk("pf_last_word", words[9], 32'h0007_0109);
    chk("pf_frames", 32'(frame_cnt), 32'd3);

    // Reset after the fifth word of a burst.
    words.delete(); wcyc.delete();
    for (int k = 0; k < 10; k++) send(16'h00A0 + 16'(k), 1'b0);
    begin
      int n;
      n = 0;
      while (words.size() < 5 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("abort_pre", 32'(words.size()), 32'd5);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_words", 32'(words.size()), 32'd5);
    chk("abort_cnt",   32'(frame_cnt),    32'd0);
    words.delete(); wcyc.delete();
    send(16'h00B1, 1'b0);
    send(16'h00B2, 1'b1);
    wait_words(10, "post_abort_cnt");
    chk("post_abort_w0", words[0], 32'h0007_00B1);
    chk("post_abort_w1", words[1], 32'h0007_00B2);
    chk("post_abort_w2", words[2], 32'h0005_0000);
    chk("post_abort_w9", words[9], 32'h0005_0000);
    chk("post_abort_frames", 32'(frame_cnt), 32'd1);

    // Frame counter wrap.
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    chk("wrap_pre", 32'(frame_cnt), 32'h0000_FFFF);
    words.delete(); wcyc.delete();
    send(16'hC0DE, 1'b1);
    wait_words(10, "wrap_words");
    chk("wrap_cnt", 32'(frame_cnt), 32'h0);

    // Sparse valid, with smp_last on the final slot: full frame, no padding.
    words.delete(); wcyc.delete();
    for (int k = 0; k < 10; k++) begin
      send(16'h5A00 + 16'(k), (k == 9));
      @(negedge clk);
    end
    wait_words(10, "sparse_cnt");
    for (int k = 0; k < 10; k++) chk("sparse_word", words[k], 32'h0007_5A00 + 32'(k));
    repeat (15) @(negedge clk);
    chk("sparse_no_extra", 32'(words.size()), 32'd10);
    chk("sparse_frames",   32'(frame_cnt),    32'd1);

    chk("ready_in_burst", 32'(rdy_viol),  32'd0);
    chk("dout_idle_zero", 32'(dout_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
